// File: rtl/pmod_pwm_demod.sv
// PWM line receiver: synchronises pwm_in, aligns a 2**PERIOD_LOG2 window to a rising
// edge, counts high cycles and emits a saturated signed sample once per window.
module pmod_pwm_demod #(
  parameter int PERIOD_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pwm_in,
  output logic signed [7:0] sample,
  output logic              sample_valid,
  output logic              locked,
  output logic              stuck
);

  localparam int N = PERIOD_LOG2;
  localparam logic [N-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    sync_reg;
  logic          s_d_reg;
  logic [N-1:0]  tmo_reg;
  logic [N-1:0]  cnt_reg;
  logic [N:0]    acc_reg;
  logic          edge_seen_reg;

  logic          s, rise, any_edge;
  logic          lock_go, tmo_go, close;
  logic [N:0]    total;
  logic [8:0]    scaled;

  assign s        = sync_reg[1];
  assign rise     = s & ~s_d_reg;
  assign any_edge = s ^ s_d_reg;
  assign total    = acc_reg + {{N{1'b0}}, s};
  // total >> (N-8), of which only the low 9 bits can be non-zero
  assign scaled   = total[N:N-8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg  <= '0;
      s_d_reg   <= 1'b0;
      state_reg <= IDLE;
    end else begin
      sync_reg  <= {sync_reg[0], pwm_in};
      s_d_reg   <= s;
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    lock_go    = 1'b0;
    tmo_go     = 1'b0;
    close      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) state_next = ACQUIRE;
      end
      ACQUIRE: begin
        if (!en) begin
          state_next = IDLE;
        end else if (rise) begin
          state_next = MEASURE;
          lock_go    = 1'b1;
        end else if (tmo_reg == CNT_MAX) begin
          state_next = MEASURE;
          tmo_go     = 1'b1;
        end
      end
      MEASURE: begin
        // a close coinciding with en dropping is still reported
        close = (cnt_reg == CNT_MAX);
        if (!en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_reg       <= '0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      edge_seen_reg <= 1'b0;
    end else begin
      tmo_reg <= (state_reg == ACQUIRE && en) ? tmo_reg + 1'b1 : '0;
      if (lock_go) begin
        // the lock edge cycle is window cycle 0 and its high level counts
        cnt_reg       <= {{(N-1){1'b0}}, 1'b1};
        acc_reg       <= {{N{1'b0}}, 1'b1};
        edge_seen_reg <= 1'b1;
      end else if (state_reg == MEASURE && en) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (close) begin
          acc_reg       <= '0;
          edge_seen_reg <= 1'b0;
        end else begin
          acc_reg       <= acc_reg + {{N{1'b0}}, s};
          edge_seen_reg <= edge_seen_reg | any_edge;
        end
      end else begin
        cnt_reg       <= '0;
        acc_reg       <= '0;
        edge_seen_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      stuck        <= 1'b0;
    end else begin
      sample_valid <= close;
      if (close) begin
        sample <= scaled[8] ? 8'sd127 : $signed({~scaled[7], scaled[6:0]});
        stuck  <= ~(edge_seen_reg | any_edge);
      end
      if (lock_go) locked <= 1'b1;
      else if (tmo_go) locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pmod_pwm_demod.sv
// Bench for pmod_pwm_demod: frame-based PWM generators feed an 8-bit and a 10-bit
// instance; each sample is predicted from the duty of the frame it should cover.
module tb_pmod_pwm_demod;

  localparam int P8 = 8, N8 = 256, P10 = 10, N10 = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic en8 = 1'b0, pwm8 = 1'b0, en10 = 1'b0, pwm10 = 1'b0;
  logic signed [7:0] sample8, sample10;
  logic valid8, valid10, locked8, locked10, stuck8, stuck10;

  pmod_pwm_demod #(.PERIOD_LOG2(P8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .pwm_in(pwm8),
    .sample(sample8), .sample_valid(valid8), .locked(locked8), .stuck(stuck8)
  );

  pmod_pwm_demod #(.PERIOD_LOG2(P10)) dut10 (
    .clk(clk), .rst(rst), .en(en10), .pwm_in(pwm10),
    .sample(sample10), .sample_valid(valid10), .locked(locked10), .stuck(stuck10)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int duty8 = 0, duty10 = 0, cur8 = 0, cur10 = 0;
  int fd8[int];
  int fd10[int];
  int strobes8 = 0, strobes10 = 0;

  // Frame generators: frames start at multiples of N, duty latched at frame start.
  initial forever begin
    @(negedge clk);
    if (cyc % N8 == 0) begin
      cur8 = duty8;
      fd8[cyc] = cur8;
    end
    pwm8 = ((cyc % N8) < cur8);
  end

  initial forever begin
    @(negedge clk);
    if (cyc % N10 == 0) begin
      cur10 = duty10;
      fd10[cyc] = cur10;
    end
    pwm10 = ((cyc % N10) < cur10);
  end

  initial forever begin
    @(negedge clk);
    if (valid8) strobes8++;
    if (valid10) strobes10++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_sample(input int d, input int p);
    int sc;
    sc = d >> (p - 8);
    if (sc > 255) return 127;
    return sc - 128;
  endfunction

  // A window is stuck when the line never changes level across it, counting the
  // boundary from the previous frame's last cycle into cycle 0.
  function automatic int exp_stuck(input int d, input int dp, input int n);
    bit first_hi, prev_hi, inner;
    first_hi = (d > 0);
    prev_hi  = (dp == n);
    inner    = (d > 0) && (d < n);
    return ((first_hi != prev_hi) || inner) ? 0 : 1;
  endfunction

  function automatic int lock_strobe(input int e, input int n);
    int f;
    f = ((e - 1 + n - 1) / n) * n;
    return f + n + 2;
  endfunction

  task automatic wait_strobe(input bit is10, input int limit, output int c,
                             output int smp, output int stk, output int lck);
    c = -1; smp = 0; stk = 0; lck = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (is10 ? valid10 : valid8) begin
        c   = cyc;
        smp = is10 ? int'(sample10) : int'(sample8);
        stk = is10 ? int'(stuck10) : int'(stuck8);
        lck = is10 ? int'(locked10) : int'(locked8);
        break;
      end
    end
    check("strobe_seen", int'(c >= 0), 1);
    if (c >= 0) begin
      @(negedge clk);
      check("valid_one_cycle", is10 ? int'(valid10) : int'(valid8), 0);
    end
  endtask

  task automatic check_window(input bit is10, input int c, input int smp, input int stk);
    int n, p, f, d, dp;
    bit ok;
    n = is10 ? N10 : N8;
    p = is10 ? P10 : P8;
    f = c - n - 2;
    ok = is10 ? fd10.exists(f) : fd8.exists(f);
    check("window_aligned", int'(ok), 1);
    d  = ok ? (is10 ? fd10[f] : fd8[f]) : -1;
    dp = 0;
    if (is10 ? fd10.exists(f - n) : fd8.exists(f - n)) dp = is10 ? fd10[f - n] : fd8[f - n];
    check("sample", smp, exp_sample(d, p));
    check("stuck", stk, exp_stuck(d, dp, n));
    $display("strobe dut%0d cyc=%0d duty=%0d sample=%0d stuck=%0d", p, c, d, smp, stk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  int c, prev_c, e, smp, stk, lck, held, s0;
  int vals[6] = '{128, 1, 0, 256, 256, 64};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sample", int'(sample8), 0);
    check("rst_valid", int'(valid8), 0);
    check("rst_locked", int'(locked8), 0);
    check("rst_stuck", int'(stuck8), 0);
    check("rst_sample10", int'(sample10), 0);
    rst = 1'b0;

    // Constant-low line: timeout path
    repeat (5) @(negedge clk);
    e = cyc;
    en8 = 1'b1;
    wait_strobe(0, 700, c, smp, stk, lck);
    check("timeout_latency", c, e + 513);
    check("timeout_sample", smp, -128);
    check("timeout_stuck", stk, 1);
    check("timeout_locked", lck, 0);
    prev_c = c;
    wait_strobe(0, 300, c, smp, stk, lck);
    check("timeout_spacing", c - prev_c, N8);
    check("timeout_sample2", smp, -128);
    en8 = 1'b0;

    // Nominal duty: lock path
    duty8 = 192;
    repeat (10) @(negedge clk);
    e = cyc;
    en8 = 1'b1;
    wait_strobe(0, 700, c, smp, stk, lck);
    check("lock_latency", c, lock_strobe(e, N8));
    check("lock_locked", lck, 1);
    check_window(0, c, smp, stk);
    for (int i = 0; i < 2; i++) begin
      prev_c = c;
      wait_strobe(0, 300, c, smp, stk, lck);
      check("nominal_spacing", c - prev_c, N8);
      check_window(0, c, smp, stk);
    end

    // Directed boundary duties followed by random ones
    for (int i = 0; i < 14; i++) begin
      duty8 = (i < 6) ? vals[i] : int'($urandom_range(0, N8));
      prev_c = c;
      wait_strobe(0, 300, c, smp, stk, lck);
      check("run_spacing", c - prev_c, N8);
      check_window(0, c, smp, stk);
    end

    // Enable drop mid-window
    duty8 = 128;
    for (int i = 0; i < 3; i++) wait_strobe(0, 300, c, smp, stk, lck);
    held = int'(sample8);
    wait_until(c + 50);
    s0 = strobes8;
    en8 = 1'b0;
    wait_until(c + 450);
    check("drop_no_strobe", strobes8 - s0, 0);
    check("drop_sample_held", int'(sample8), held);
    check("drop_locked_held", int'(locked8), 1);
    e = cyc;
    en8 = 1'b1;
    wait_strobe(0, 700, c, smp, stk, lck);
    check("reenable_latency", c, lock_strobe(e, N8));
    check_window(0, c, smp, stk);

    // Reset at window cycle 100
    duty8 = 192;
    for (int i = 0; i < 2; i++) wait_strobe(0, 300, c, smp, stk, lck);
    wait_until(c + 100);
    s0 = strobes8;
    rst = 1'b1;
    #1;
    check("midrst_sample", int'(sample8), 0);
    check("midrst_locked", int'(locked8), 0);
    check("midrst_stuck", int'(stuck8), 0);
    check("midrst_valid", int'(valid8), 0);
    @(negedge clk);
    while (cyc % N8 != 200) @(negedge clk);
    rst = 1'b0;
    e = cyc;
    check("midrst_no_strobe", strobes8 - s0, 0);
    wait_strobe(0, 700, c, smp, stk, lck);
    check("rst_reacq_latency", c, lock_strobe(e, N8));
    check("rst_reacq_locked", lck, 1);
    check_window(0, c, smp, stk);
    en8 = 1'b0;

    // Scaling with a 1024-cycle frame
    duty10 = 768;
    repeat (10) @(negedge clk);
    e = cyc;
    en10 = 1'b1;
    wait_strobe(1, 2500, c, smp, stk, lck);
    check("p10_latency", c, lock_strobe(e, N10));
    check("p10_locked", lck, 1);
    check("p10_sample", smp, 64);
    check_window(1, c, smp, stk);
    duty10 = int'($urandom_range(1, N10 - 1));
    for (int i = 0; i < 2; i++) begin
      prev_c = c;
      wait_strobe(1, 1200, c, smp, stk, lck);
      check("p10_spacing", c - prev_c, N10);
      check_window(1, c, smp, stk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
